// File: rtl/loader_pkg.sv
// Shared types and the boot image for the program loader.
// The image is a run of addi rd, x0, imm instructions used as the default boot program.
package loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StVerify,
        StVdrain,
        StDone,
        StError
    } loader_state_t;

    localparam int unsigned IMG_WORDS_DEF = 64;
    localparam logic [31:0] NOP_WORD      = 32'h0000_0013;

    localparam logic [31:0] PROG_IMAGE [IMG_WORDS_DEF] = '{
        32'h0000_0093, 32'h0010_0113, 32'h0020_0193, 32'h0030_0213,
        32'h0040_0293, 32'h0050_0313, 32'h0060_0393, 32'h0070_0413,
        32'h0080_0493, 32'h0090_0513, 32'h00A0_0593, 32'h00B0_0613,
        32'h00C0_0693, 32'h00D0_0713, 32'h00E0_0793, 32'h00F0_0813,
        32'h0100_0893, 32'h0110_0913, 32'h0120_0993, 32'h0130_0A13,
        32'h0140_0A93, 32'h0150_0B13, 32'h0160_0B93, 32'h0170_0C13,
        32'h0180_0C93, 32'h0190_0D13, 32'h01A0_0D93, 32'h01B0_0E13,
        32'h01C0_0E93, 32'h01D0_0F13, 32'h01E0_0F93, 32'h01F0_0093,
        32'h0200_0113, 32'h0210_0193, 32'h0220_0213, 32'h0230_0293,
        32'h0240_0313, 32'h0250_0393, 32'h0260_0413, 32'h0270_0493,
        32'h0280_0513, 32'h0290_0593, 32'h02A0_0613, 32'h02B0_0693,
        32'h02C0_0713, 32'h02D0_0793, 32'h02E0_0813, 32'h02F0_0893,
        32'h0300_0913, 32'h0310_0993, 32'h0320_0A13, 32'h0330_0A93,
        32'h0340_0B13, 32'h0350_0B93, 32'h0360_0C13, 32'h0370_0C93,
        32'h0380_0D13, 32'h0390_0D93, 32'h03A0_0E13, 32'h03B0_0E93,
        32'h03C0_0F13, 32'h03D0_0F93, 32'h03E0_0093, 32'h03F0_0113
    };

endpackage

// File: rtl/prog_image_rom.sv
// Combinational lookup of the boot image; indices past the image return a NOP.
module prog_image_rom
    import loader_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 7
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] word
);

    localparam int unsigned ROM_AW = $clog2(IMG_WORDS_DEF);

    logic [31:0] idx_ext;

    assign idx_ext = 32'(idx);

    always_comb begin
        word = DATA_W'(NOP_WORD);
        if (idx_ext < 32'(IMG_WORDS_DEF)) begin
            word = DATA_W'(PROG_IMAGE[idx_ext[ROM_AW-1:0]]);
        end
    end

endmodule

// File: rtl/prog_image_loader.sv
// Boot loader: copies the image into RAM, optionally reads it back and compares,
// and holds the CPU in reset until the image is in place.
module prog_image_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned IMG_WORDS  = IMG_WORDS_DEF,
    parameter int unsigned START_ADDR = 0,
    parameter bit          VERIFY     = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    output logic              mem_rden,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic              cpu_hold
);

    localparam int unsigned       IDX_W    = $clog2(IMG_WORDS + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(IMG_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(START_ADDR);

    // The image must fit above START_ADDR without wrapping the address space.
    if (IMG_WORDS < 1 || 64'(START_ADDR) + 64'(IMG_WORDS) > (64'd1 << ADDR_W)) begin : g_bad_cfg
        $fatal(1, "prog_image_loader: image does not fit in RAM above START_ADDR");
    end

    loader_state_t     state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  cmp_idx_q, cmp_idx_d;
    logic              cmp_vld_q, cmp_vld_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              auto_go_q, auto_go_d;

    logic [IDX_W-1:0]  rom_idx;
    logic [DATA_W-1:0] rom_word;
    logic              mismatch;

    // One ROM port serves both passes: write index while writing, compare index otherwise.
    assign rom_idx  = (state_q == StWrite) ? idx_q : cmp_idx_q;
    assign mismatch = cmp_vld_q && (mem_q != rom_word);

    prog_image_rom #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_rom (
        .idx  (rom_idx),
        .word (rom_word)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cmp_idx_d  = cmp_idx_q;
        cmp_vld_d  = 1'b0;
        done_d     = done_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        auto_go_d  = auto_go_q;

        unique case (state_q)
            StIdle: begin
                if (auto_go_q) begin
                    state_d   = StWrite;
                    auto_go_d = 1'b0;
                    idx_d     = '0;
                end
            end
            StWrite: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = VERIFY ? StVerify : StDone;
                    done_d  = !VERIFY;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StVerify: begin
                if (mismatch) begin
                    state_d    = StError;
                    err_d      = 1'b1;
                    err_addr_d = BASE + ADDR_W'(cmp_idx_q);
                end else begin
                    cmp_vld_d = 1'b1;
                    cmp_idx_d = idx_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = StVdrain;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StVdrain: begin
                if (mismatch) begin
                    state_d    = StError;
                    err_d      = 1'b1;
                    err_addr_d = BASE + ADDR_W'(cmp_idx_q);
                end else begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            StDone, StError: begin
                if (start) begin
                    state_d    = StWrite;
                    idx_d      = '0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    err_addr_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            cmp_idx_q  <= '0;
            cmp_vld_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            auto_go_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cmp_idx_q  <= cmp_idx_d;
            cmp_vld_q  <= cmp_vld_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            auto_go_q  <= auto_go_d;
        end
    end

    // A mismatch suppresses the read issued in the same cycle.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        mem_rden  = 1'b0;
        if (Reset_n) begin
            if (state_q == StWrite) begin
                mem_wren  = 1'b1;
                mem_addr  = BASE + ADDR_W'(idx_q);
                mem_wdata = rom_word;
            end else if (state_q == StVerify && !mismatch) begin
                mem_rden = 1'b1;
                mem_addr = BASE + ADDR_W'(idx_q);
            end
        end
    end

    assign busy     = !Reset_n || !(state_q inside {StDone, StError});
    assign done     = done_q;
    assign err      = err_q;
    assign err_addr = err_addr_q;
    assign cpu_hold = !done_q;

endmodule

// File: tb/tb_prog_image_loader.sv
// Bench for prog_image_loader: three configurations against behavioural RAMs,
// checked every cycle against a timeline model plus hand-computed literals.
module tb_prog_image_loader;

    localparam int N = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic start = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0]  m_addr, m_err_addr, n_addr, n_err_addr, h_addr, h_err_addr;
    logic [31:0] m_wdata, m_q, n_wdata, h_wdata, h_q;
    logic        m_wren, m_rden, m_busy, m_done, m_err, m_hold;
    logic        n_wren, n_rden, n_busy, n_done, n_err, n_hold;
    logic        h_wren, h_rden, h_busy, h_done, h_err, h_hold;

    prog_image_loader #(
        .ADDR_W(10), .DATA_W(32), .IMG_WORDS(64), .START_ADDR(0), .VERIFY(1'b1)
    ) u_main (
        .Clk(clk), .Reset_n(rst_n), .start(start), .mem_addr(m_addr), .mem_wdata(m_wdata),
        .mem_wren(m_wren), .mem_rden(m_rden), .mem_q(m_q), .busy(m_busy), .done(m_done),
        .err(m_err), .err_addr(m_err_addr), .cpu_hold(m_hold)
    );

    prog_image_loader #(
        .ADDR_W(10), .DATA_W(32), .IMG_WORDS(4), .START_ADDR(0), .VERIFY(1'b0)
    ) u_nv (
        .Clk(clk), .Reset_n(rst_n), .start(1'b0), .mem_addr(n_addr), .mem_wdata(n_wdata),
        .mem_wren(n_wren), .mem_rden(n_rden), .mem_q(32'h0), .busy(n_busy), .done(n_done),
        .err(n_err), .err_addr(n_err_addr), .cpu_hold(n_hold)
    );

    prog_image_loader #(
        .ADDR_W(10), .DATA_W(32), .IMG_WORDS(24), .START_ADDR(1000), .VERIFY(1'b1)
    ) u_hi (
        .Clk(clk), .Reset_n(rst_n), .start(1'b0), .mem_addr(h_addr), .mem_wdata(h_wdata),
        .mem_wren(h_wren), .mem_rden(h_rden), .mem_q(h_q), .busy(h_busy), .done(h_done),
        .err(h_err), .err_addr(h_err_addr), .cpu_hold(h_hold)
    );

    // Image content: addi x((i mod 31)+1), x0, i
    function automatic logic [31:0] img(input int i);
        if (i < 0 || i >= 64) return 32'h0000_0013;
        return (32'(i) << 20) | (32'((i % 31) + 1) << 7) | 32'h13;
    endfunction

    function automatic int end_of(input int b);
        return (b >= 0) ? N + 3 + b : 2 * N + 2;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural RAMs; corrupt_idx flips bit 0 on readback of that main-RAM word.
    logic [31:0] ram_m [1024];
    logic [31:0] ram_h [1024];
    int corrupt_idx = -1;
    int h_max_waddr = 0;

    always @(posedge clk) begin
        if (m_wren) ram_m[m_addr] <= m_wdata;
        if (m_rden) m_q <= ram_m[m_addr] ^
            ((corrupt_idx >= 0 && int'(m_addr) == corrupt_idx) ? 32'h1 : 32'h0);
        if (h_wren) ram_h[h_addr] <= h_wdata;
        if (h_rden) h_q <= ram_h[h_addr];
        if (h_wren && int'(h_addr) > h_max_waddr) h_max_waddr <= int'(h_addr);
    end

    // Timeline model: t = cycles since the IDLE cycle or since an accepted start.
    int t = 0;
    int ta = 0;
    int run_bad = -1;

    always @(posedge clk) begin
        if (!rst_n) begin
            t       <= 0;
            ta      <= 0;
            run_bad <= corrupt_idx;
        end else begin
            if (ta < 100000) ta <= ta + 1;
            if (start && t >= end_of(run_bad)) begin
                t       <= 1;
                run_bad <= corrupt_idx;
            end else if (t < 100000) begin
                t <= t + 1;
            end
        end
    end

    logic m_done_prev = 1'b0;

    always @(negedge clk) begin
        int  rd_last, e_addr;
        bit  e_wren, e_rden, term, e_done, e_err;
        if (!rst_n) begin
            chk("rst_m_wren", m_wren, 0);
            chk("rst_m_rden", m_rden, 0);
            chk("rst_m_busy", m_busy, 1);
            chk("rst_n_wren", n_wren, 0);
            chk("rst_h_wren", h_wren, 0);
            chk("rst_h_rden", h_rden, 0);
        end else begin
            rd_last = (run_bad >= 0) ? N + 1 + run_bad : 2 * N;
            e_wren  = (t >= 1 && t <= N);
            e_rden  = (t >= N + 1 && t <= rd_last);
            e_addr  = e_wren ? t - 1 : (e_rden ? t - N - 1 : 0);
            term    = (t >= end_of(run_bad));
            e_done  = term && run_bad < 0;
            e_err   = term && run_bad >= 0;
            chk("m_wren", m_wren, e_wren);
            chk("m_rden", m_rden, e_rden);
            chk("m_addr", m_addr, e_addr);
            chk("m_wdata", m_wdata, e_wren ? img(t - 1) : 32'h0);
            chk("m_busy", m_busy, !term);
            chk("m_done", m_done, e_done);
            chk("m_err", m_err, e_err);
            chk("m_err_addr", m_err_addr, e_err ? run_bad : 0);
            chk("m_cpu_hold", m_hold, !e_done);
            if (m_done && !m_done_prev) chk("done_rise_cycle", t, 130);

            // VERIFY=0, 4 words at address 0
            e_wren = (ta >= 1 && ta <= 4);
            chk("n_wren", n_wren, e_wren);
            chk("n_rden", n_rden, 0);
            chk("n_addr", n_addr, e_wren ? ta - 1 : 0);
            chk("n_wdata", n_wdata, e_wren ? img(ta - 1) : 32'h0);
            chk("n_done", n_done, ta >= 5);
            chk("n_cpu_hold", n_hold, ta < 5);

            // 24 words at 1000..1023 with verify
            e_wren = (ta >= 1 && ta <= 24);
            e_rden = (ta >= 25 && ta <= 48);
            chk("h_wren", h_wren, e_wren);
            chk("h_rden", h_rden, e_rden);
            chk("h_addr", h_addr, e_wren ? 999 + ta : (e_rden ? 975 + ta : 0));
            chk("h_done", h_done, ta >= 50);
            chk("h_err", h_err, 0);
        end
        m_done_prev <= m_done;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        repeat (3) cycle();
        chk("reset_busy", m_busy, 1);
        chk("reset_done", m_done, 0);
        chk("reset_err", m_err, 0);
        chk("reset_err_addr", m_err_addr, 0);
        chk("reset_cpu_hold", m_hold, 1);
        rst_n = 1'b1;

        // Load after reset release, then inspect RAM contents
        repeat (135) cycle();
        chk("a_done", m_done, 1);
        for (int i = 0; i < N; i++) chk("ram_m_word", ram_m[i], img(i));
        chk("ram_m_0_lit", ram_m[0], 32'h0000_0093);
        chk("ram_m_17_lit", ram_m[17], 32'h0110_0913);
        chk("ram_m_63_lit", ram_m[63], 32'h03F0_0113);
        chk("h_last_waddr", h_max_waddr, 1023);
        chk("ram_h_1023_lit", ram_h[1023], 32'h0170_0C13);
        chk("ram_h_1000_lit", ram_h[1000], 32'h0000_0093);
        chk("h_done_lit", h_done, 1);
        chk("n_done_lit", n_done, 1);

        // Reload from DONE; a start pulse mid-write is ignored
        pulse_start();
        chk("b_done_dropped", m_done, 0);
        repeat (9) cycle();
        pulse_start();
        repeat (125) cycle();
        chk("b_done", m_done, 1);

        // Word 17 read back with bit 0 flipped
        corrupt_idx = 17;
        pulse_start();
        repeat (100) cycle();
        chk("c_err", m_err, 1);
        chk("c_err_addr_lit", m_err_addr, 10'd17);
        chk("c_done", m_done, 0);
        chk("c_cpu_hold", m_hold, 1);
        chk("c_busy", m_busy, 0);

        // Restart from ERROR, then a one-cycle reset while idx 30 is being written
        corrupt_idx = -1;
        pulse_start();
        chk("d_err_cleared", m_err, 0);
        repeat (30) cycle();
        rst_n = 1'b0;
        #1;
        chk("d_wren_in_reset", m_wren, 0);
        cycle();
        rst_n = 1'b1;
        repeat (135) cycle();
        chk("d_done", m_done, 1);
        chk("d_err", m_err, 0);
        for (int i = 0; i < N; i++) chk("d_ram_m_word", ram_m[i], img(i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
